// File: rtl/sha256_compress_pkg.sv
//------------------------------------------------------------------------------
// sha256_pkg : SHA-256 round constants, IVs, round functions, core state enum
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_compress_if.sv
//------------------------------------------------------------------------------
// sha256_compress_if : start/W-word/digest bundle for the compression core.
// Optional macro SHA224_SUPPORT_EN adds mode224.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sha256_compress_if;
  logic         start;
  logic         first_blk;
  logic [31:0]  w_in;
  logic         w_valid;
  logic         w_ready;
  logic         busy;
  logic         done;
  logic [255:0] digest;
`ifdef SHA224_SUPPORT_EN
  logic         mode224;
`endif

  modport master (
`ifdef SHA224_SUPPORT_EN
    output mode224,
`endif
    output start, first_blk, w_in, w_valid,
    input  w_ready, busy, done, digest
  );

  modport slave (
`ifdef SHA224_SUPPORT_EN
    input  mode224,
`endif
    input  start, first_blk, w_in, w_valid,
    output w_ready, busy, done, digest
  );
endinterface

`default_nettype wire

// File: rtl/sha256_round.sv
//------------------------------------------------------------------------------
// sha256_round : one combinational SHA-256 round; state packed {a,...,h}, a MSW.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] state_o
);
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;
  assign t1 = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = bsig0(a) + maj(a, b, c);
  assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

`default_nettype wire

// File: rtl/sha256_compress.sv
//------------------------------------------------------------------------------
// sha256_compress : SHA-256 compression core, one round per accepted W word,
// digest chained across blocks. Optional macro SHA224_SUPPORT_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sha256_compress
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sha256_compress_if.slave        bus
);
  localparam int TW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [255:0]    work_q, work_d;
  logic [255:0]    hsh_q, hsh_d;
  logic [255:0]    digest_q, digest_d;
  logic            done_q, done_d;
  logic [255:0]    round_out, h_base, final_sum;

  sha256_round u_round (
    .state_i (work_q),
    .k_i     (K[t_q]),
    .w_i     (bus.w_in),
    .state_o (round_out)
  );

  for (genvar i = 0; i < 8; i++) begin : g_final
    assign final_sum[32*i +: 32] = hsh_q[32*i +: 32] + work_q[32*i +: 32];
  end

`ifdef SHA224_SUPPORT_EN
  // mode_q follows the running block; dmode_q follows the digest on display.
  logic mode_q, mode_d, dmode_q, dmode_d;
  assign h_base     = !bus.first_blk ? digest_q : (bus.mode224 ? IV224 : IV256);
  assign bus.digest = dmode_q ? {digest_q[255:32], 32'h0} : digest_q;
`else
  assign h_base     = bus.first_blk ? IV256 : digest_q;
  assign bus.digest = digest_q;
`endif

  assign bus.w_ready = (state_q == ROUND);
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    work_d   = work_q;
    hsh_d    = hsh_q;
    digest_d = digest_q;
    done_d   = 1'b0;
`ifdef SHA224_SUPPORT_EN
    mode_d   = mode_q;
    dmode_d  = dmode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = h_base;
          hsh_d   = h_base;
          t_d     = '0;
          state_d = ROUND;
`ifdef SHA224_SUPPORT_EN
          mode_d  = bus.mode224;
`endif
        end
      end
      ROUND: begin
        if (bus.w_valid) begin
          work_d = round_out;
          t_d    = t_q + 1'b1;
          if (t_q == TW'(ROUNDS - 1)) state_d = FINAL;
        end
      end
      FINAL: begin
        digest_d = final_sum;
        done_d   = 1'b1;
        state_d  = IDLE;
`ifdef SHA224_SUPPORT_EN
        dmode_d  = mode_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      t_q      <= '0;
      work_q   <= '0;
      hsh_q    <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
`ifdef SHA224_SUPPORT_EN
      mode_q   <= 1'b0;
      dmode_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      work_q   <= work_d;
      hsh_q    <= hsh_d;
      digest_q <= digest_d;
      done_q   <= done_d;
`ifdef SHA224_SUPPORT_EN
      mode_q   <= mode_d;
      dmode_q  <= dmode_d;
`endif
    end
  end
endmodule

`default_nettype wire
